// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a length-prefixed byte stream and writes 32-bit big-endian words
// from address 0 upward. The core is held in reset until a load completes successfully.
module imem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR} state_t;

  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_WIDTH);

  state_t                state_q, state_d;
  logic [7:0]            lenHi_q, lenHi_d;
  logic [1:0]            byteCnt_q, byteCnt_d;
  logic [15:0]           wordsLeft_q, wordsLeft_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [31:0]           wdata_d;
  logic                  accept;
  logic [15:0]           lenFull;

  assign accept  = rx_valid && rx_ready;
  assign lenFull = {lenHi_q, rx_data};

  always_comb begin
    state_d     = state_q;
    lenHi_d     = lenHi_q;
    byteCnt_d   = byteCnt_q;
    wordsLeft_d = wordsLeft_q;
    addr_d      = imem_addr;
    wdata_d     = imem_wdata;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d   = LEN_HI;
          addr_d    = '0;
          byteCnt_d = 2'd0;
        end
      end
      LEN_HI: begin
        if (accept) begin
          lenHi_d = rx_data;
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          if (lenFull == 16'd0) begin
            state_d = DONE;
          end else if ({1'b0, lenFull} > DEPTH) begin
            state_d = ERR;
          end else begin
            state_d     = DATA;
            wordsLeft_d = lenFull;
          end
        end
      end
      DATA: begin
        if (accept) begin
          wdata_d   = {imem_wdata[23:0], rx_data};
          byteCnt_d = byteCnt_q + 2'd1;
          if (byteCnt_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        // Address advances after the write cycle, so the wrapped value after the last word is never written.
        addr_d      = imem_addr + ADDR_WIDTH'(1);
        wordsLeft_d = wordsLeft_q - 16'd1;
        state_d     = (wordsLeft_q == 16'd1) ? DONE : DATA;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lenHi_q     <= 8'd0;
      byteCnt_q   <= 2'd0;
      wordsLeft_q <= 16'd0;
      imem_addr   <= '0;
      imem_wdata  <= 32'd0;
      rx_ready    <= 1'b0;
      imem_we     <= 1'b0;
      core_rst    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lenHi_q     <= lenHi_d;
      byteCnt_q   <= byteCnt_d;
      wordsLeft_q <= wordsLeft_d;
      imem_addr   <= addr_d;
      imem_wdata  <= wdata_d;
      rx_ready    <= (state_d == LEN_HI) || (state_d == LEN_LO) || (state_d == DATA);
      imem_we     <= (state_d == WRITE);
      busy        <= (state_d == LEN_HI) || (state_d == LEN_LO) || (state_d == DATA) ||
                     (state_d == WRITE);
      done        <= (state_d == DONE);
      error       <= (state_d == ERR);
      core_rst    <= (state_d != DONE);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (ADDR_WIDTH=4): normal, empty, oversize, boundary, gapped,
// reset-abort and start-while-busy frames, with per-cycle protocol checks on the outputs.
module tb_imem_loader;

  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          rst, start, rxValid;
  logic [7:0]    rxData;
  logic          rxReady, imemWe, coreRst, busy, done, error;
  logic [AW-1:0] imemAddr;
  logic [31:0]   imemWdata;

  int checks = 0;
  int errors = 0;
  bit monOn  = 1'b0;
  bit prevWe = 1'b0;

  logic [31:0] logAddr[$];
  logic [31:0] logData[$];
  logic [7:0]  frame1[$];
  logic [7:0]  buf8[$];
  logic [31:0] w;
  int          base;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clock), .rst(rst), .start(start), .rx_data(rxData), .rx_valid(rxValid),
    .rx_ready(rxReady), .imem_we(imemWe), .imem_addr(imemAddr), .imem_wdata(imemWdata),
    .core_rst(coreRst), .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  // Log every memory write and check the protocol invariants once per cycle.
  always @(negedge clock) begin
    if (monOn) begin
      if (imemWe) begin
        logAddr.push_back(32'(imemAddr));
        logData.push_back(imemWdata);
      end
      checks++;
      assert (!imemWe || (busy && !rxReady && !prevWe)) else begin
        errors++;
        $error("[TB] FAIL monWe observed we=%b busy=%b ready=%b prevWe=%b", imemWe, busy, rxReady, prevWe);
      end
      checks++;
      assert (coreRst || done) else begin
        errors++;
        $error("[TB] FAIL monCoreRst observed core_rst=%b done=%b", coreRst, done);
      end
      checks++;
      assert ($onehot0({busy, done, error})) else begin
        errors++;
        $error("[TB] FAIL monExclusive observed busy/done/error=%b%b%b expected at most one", busy, done, error);
      end
      prevWe = imemWe;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one byte after a gap and hold it until the loader takes it; returns on the negedge after acceptance.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int n;
    rxValid = 1'b0;
    repeat (gap) @(negedge clock);
    rxData  = b;
    rxValid = 1'b1;
    n = 0;
    while (!rxReady && n < 50) begin
      @(negedge clock);
      n++;
    end
    checkOutput("byteAcceptTimeout", 32'(n < 50), 32'd1);
    @(negedge clock);
    rxValid = 1'b0;
  endtask

  task automatic sendQueue(input logic [7:0] q[$], input int maxGap);
    foreach (q[i]) applyStimulus(q[i], (maxGap == 0) ? 0 : int'($urandom_range(0, maxGap)));
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic checkWrite(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    if (idx < logAddr.size()) begin
      checkOutput({tag, "Addr"}, logAddr[idx], a);
      checkOutput({tag, "Data"}, logData[idx], d);
    end else begin
      checks++;
      errors++;
      $error("[TB] FAIL %s missing write index %0d expected addr=%h data=%h", tag, idx, a, d);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "RxReady"}, 32'(rxReady), 32'd0);
    checkOutput({tag, "We"}, 32'(imemWe), 32'd0);
    checkOutput({tag, "Addr"}, 32'(imemAddr), 32'd0);
    checkOutput({tag, "Wdata"}, imemWdata, 32'd0);
    checkOutput({tag, "CoreRst"}, 32'(coreRst), 32'd1);
    checkOutput({tag, "Busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "Done"}, 32'(done), 32'd0);
    checkOutput({tag, "Error"}, 32'(error), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    frame1 = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    rst = 1'b1; start = 1'b0; rxValid = 1'b0; rxData = 8'h00;
    repeat (2) @(negedge clock);
    checkResetState("reset");
    rst   = 1'b0;
    monOn = 1'b1;

    // Test 1: back-to-back two-word frame.
    base = logData.size();
    pulseStart();
    sendQueue(frame1, 0);
    checkOutput("t1WeLast", 32'(imemWe), 32'd1);
    @(negedge clock);
    checkOutput("t1Done", 32'(done), 32'd1);
    checkOutput("t1CoreRst", 32'(coreRst), 32'd0);
    checkOutput("t1Busy", 32'(busy), 32'd0);
    checkOutput("t1Count", 32'(logData.size() - base), 32'd2);
    checkWrite("t1W0", base, 32'd0, 32'hDEADBEEF);
    checkWrite("t1W1", base + 1, 32'd1, 32'h01234567);

    // Start while DONE puts the core back into reset straight away.
    pulseStart();
    checkOutput("reloadCoreRst", 32'(coreRst), 32'd1);
    checkOutput("reloadBusy", 32'(busy), 32'd1);
    checkOutput("reloadDone", 32'(done), 32'd0);
    checkOutput("reloadReady", 32'(rxReady), 32'd1);

    // Test 2: zero-length frame.
    base = logData.size();
    buf8 = '{8'h00, 8'h00};
    sendQueue(buf8, 0);
    checkOutput("t2Done", 32'(done), 32'd1);
    checkOutput("t2CoreRst", 32'(coreRst), 32'd0);
    checkOutput("t2Busy", 32'(busy), 32'd0);
    checkOutput("t2NoWrite", 32'(logData.size() - base), 32'd0);

    // Test 3: LEN=17 exceeds 16-word memory, then recovery.
    base = logData.size();
    pulseStart();
    buf8 = '{8'h00, 8'h11};
    sendQueue(buf8, 0);
    checkOutput("t3Error", 32'(error), 32'd1);
    checkOutput("t3Ready", 32'(rxReady), 32'd0);
    checkOutput("t3CoreRst", 32'(coreRst), 32'd1);
    checkOutput("t3Busy", 32'(busy), 32'd0);
    checkOutput("t3NoWrite", 32'(logData.size() - base), 32'd0);
    pulseStart();
    checkOutput("t3ErrCleared", 32'(error), 32'd0);
    buf8 = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    sendQueue(buf8, 0);
    @(negedge clock);
    checkOutput("t3Done", 32'(done), 32'd1);
    checkOutput("t3Count", 32'(logData.size() - base), 32'd1);
    checkWrite("t3W0", base, 32'd0, 32'h11223344);

    // High length byte alone must also trigger the oversize check (LEN=256).
    pulseStart();
    buf8 = '{8'h01, 8'h00};
    sendQueue(buf8, 0);
    checkOutput("lenHiError", 32'(error), 32'd1);

    // Boundary: LEN=16 fills the memory exactly and the address wraps to 0.
    base = logData.size();
    pulseStart();
    buf8 = '{8'h00, 8'h10};
    for (int i = 0; i < 16; i++) begin
      w = {8'hC0 + 8'(i), 8'h5A, 8'hA5, 8'(i)};
      buf8.push_back(w[31:24]); buf8.push_back(w[23:16]);
      buf8.push_back(w[15:8]);  buf8.push_back(w[7:0]);
    end
    sendQueue(buf8, 0);
    @(negedge clock);
    checkOutput("fullDone", 32'(done), 32'd1);
    checkOutput("fullAddrWrap", 32'(imemAddr), 32'd0);
    checkOutput("fullCount", 32'(logData.size() - base), 32'd16);
    for (int i = 0; i < 16; i++)
      checkWrite("fullW", base + i, 32'(i), {8'hC0 + 8'(i), 8'h5A, 8'hA5, 8'(i)});

    // Test 4: test-1 frame with random valid gaps.
    base = logData.size();
    pulseStart();
    sendQueue(frame1, 3);
    @(negedge clock);
    checkOutput("t4Done", 32'(done), 32'd1);
    checkOutput("t4Count", 32'(logData.size() - base), 32'd2);
    checkWrite("t4W0", base, 32'd0, 32'hDEADBEEF);
    checkWrite("t4W1", base + 1, 32'd1, 32'h01234567);

    // Test 5: reset after six bytes (the first word's write is in progress), then a clean reload.
    base = logData.size();
    pulseStart();
    for (int i = 0; i < 6; i++) applyStimulus(frame1[i], 0);
    rst = 1'b1;
    @(negedge clock);
    checkResetState("t5Reset");
    rst = 1'b0;
    pulseStart();
    sendQueue(frame1, 0);
    @(negedge clock);
    checkOutput("t5Done", 32'(done), 32'd1);
    checkOutput("t5Count", 32'(logData.size() - base), 32'd3);
    checkWrite("t5Partial", base, 32'd0, 32'hDEADBEEF);
    checkWrite("t5W0", base + 1, 32'd0, 32'hDEADBEEF);
    checkWrite("t5W1", base + 2, 32'd1, 32'h01234567);

    // Test 6: start pulsed mid-frame is ignored.
    base = logData.size();
    pulseStart();
    for (int i = 0; i < 5; i++) applyStimulus(frame1[i], 0);
    pulseStart();
    checkOutput("t6StillBusy", 32'(busy), 32'd1);
    for (int i = 5; i < 10; i++) applyStimulus(frame1[i], 0);
    @(negedge clock);
    checkOutput("t6Done", 32'(done), 32'd1);
    checkOutput("t6Count", 32'(logData.size() - base), 32'd2);
    checkWrite("t6W0", base, 32'd0, 32'hDEADBEEF);
    checkWrite("t6W1", base + 1, 32'd1, 32'h01234567);

    repeat (2) @(negedge clock);
    monOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
